// File: rtl/timer_counter_pkg.sv
// Shared constants and types for the memory-mapped countdown timer.
// Register offsets, CTRL bit layout, mode codes, FSM states and bridge decode windows.
package timer_counter_pkg;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_BITS     = 4;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   // Address windows the bridge decodes for the two timer instances.
   localparam logic [31:0] TC1_BASE = 32'h0000_7F00;
   localparam logic [31:0] TC1_END  = 32'h0000_7F0F;
   localparam logic [31:0] TC2_BASE = 32'h0000_7F10;
   localparam logic [31:0] TC2_END  = 32'h0000_7F1F;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   // Field order matches CTRL bit positions: im=[3], mode=[2:1], en=[0].
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } tc_ctrl_t;

   // Mode codes 1x fall back to one-shot behaviour.
   function automatic logic is_periodic(input logic [1:0] mode);
      return mode == MODE_PERIODIC;
   endfunction

endpackage

// File: rtl/timer_counter.sv
// Countdown timer responder: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// with a maskable interrupt request raised on expiry.
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [29:0]      addr,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             irq
);

   tc_state_e        state_q, state_d;
   tc_ctrl_t         ctrl_q, ctrl_d;
   logic [WIDTH-1:0] preset_q, preset_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             irq_flag_q, irq_flag_d;

   logic [1:0] reg_sel;
   logic       unused_addr;

   // addr is already a word address, so its two LSBs select the register.
   assign reg_sel     = addr[1:0];
   assign unused_addr = ^addr[29:2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_CNT;
         ST_CNT: begin
            if (!ctrl_q.en)
               state_d = ST_IDLE;
            else if (count_q <= WIDTH'(1))
               state_d = ST_INT;
         end
         ST_INT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM acts on pre-write register values; a CPU write is applied last so it wins.
   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      unique case (state_q)
         ST_LOAD: count_d = preset_q;
         ST_CNT: begin
            if (ctrl_q.en) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  count_d    = '0;
                  irq_flag_d = 1'b1;
               end
            end
         end
         ST_INT: begin
            if (is_periodic(ctrl_q.mode))
               irq_flag_d = 1'b0;
            else
               ctrl_d.en = 1'b0;
         end
         default: ;
      endcase

      if (we) begin
         unique case (reg_sel)
            OFF_CTRL: begin
               ctrl_d     = tc_ctrl_t'(wdata[CTRL_BITS-1:0]);
               irq_flag_d = 1'b0;
            end
            OFF_PRESET: preset_d = wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         OFF_CTRL:   rdata = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_q};
         OFF_PRESET: rdata = preset_q;
         OFF_COUNT:  rdata = count_q;
         default:    rdata = '0;
      endcase
      irq = irq_flag_q & ctrl_q.im;
   end

endmodule

// File: tb/tb_timer_counter.sv
// Randomized and directed bench for timer_counter against an arithmetic timing model.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   timer_counter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Phase within the count sequence, j edges after the enabling write; expiry edge is e.
   function automatic int phase(input int n, input bit periodic, input int j);
      int e;
      e = ((n < 1) ? 1 : n) + 2;
      if (periodic) return j % (e + 1);
      return (j > e) ? e : j;
   endfunction

   function automatic logic [31:0] model_count(input int n, input bit periodic, input int j);
      int e;
      int o;
      e = ((n < 1) ? 1 : n) + 2;
      o = phase(n, periodic, j);
      if (o < 2 || o >= e) return 32'd0;
      return 32'(n - (o - 2));
   endfunction

   function automatic logic model_irq(input int n, input bit periodic, input bit im, input int j);
      int e;
      e = ((n < 1) ? 1 : n) + 2;
      return im && (phase(n, periodic, j) == e);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] off, input logic [31:0] val);
      logic [31:0] up;
      up = $urandom();
      @(negedge clk);
      addr  = {up[27:0], off};
      wdata = val;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
      wdata = $urandom();
   endtask

   task automatic read_reg(input logic [1:0] off, output logic [31:0] val);
      logic [31:0] up;
      up   = $urandom();
      addr = {up[27:0], off};
      #1;
      val = rdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      we    = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      write_reg(2'd1, 32'hDEAD_BEEF);
      write_reg(2'd0, 32'hFFFF_FFFF);
      cycle();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         read_reg(2'(k), v);
         n_cmp++;
         if (v !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rdata off=%0d: got %h expected 0", k, v);
         end
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      logic [31:0] exp_c;
      do_reset();
      write_reg(2'd1, 32'd5);
      write_reg(2'd0, 32'h9);
      for (int j = 1; j <= 12; j++) begin
         cycle();
         exp_c = (j >= 2 && j <= 6) ? 32'(5 - (j - 2)) : 32'd0;
         read_reg(2'd2, v);
         n_cmp++;
         if (v !== exp_c) begin
            n_err++;
            $display("FAIL oneshot_count j=%0d: got %0d expected %0d", j, v, exp_c);
         end
         n_cmp++;
         if (irq !== (j >= 7)) begin
            n_err++;
            $display("FAIL oneshot_irq j=%0d: got %b expected %b", j, irq, (j >= 7));
         end
         read_reg(2'd0, v);
         n_cmp++;
         if (v !== ((j >= 8) ? 32'h8 : 32'h9)) begin
            n_err++;
            $display("FAIL oneshot_ctrl j=%0d: got %h expected %h", j, v, (j >= 8) ? 32'h8 : 32'h9);
         end
      end
      write_reg(2'd0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_ack k=%0d: got %b expected 0", k, irq);
         end
         cycle();
      end
   endtask

   task automatic test_periodic();
      logic [31:0] v;
      logic [31:0] exp_c;
      int o;
      int pulses;
      pulses = 0;
      do_reset();
      write_reg(2'd1, 32'd3);
      write_reg(2'd0, 32'hB);
      for (int j = 1; j <= 24; j++) begin
         cycle();
         o = j % 6;
         exp_c = (o >= 2 && o <= 4) ? 32'(3 - (o - 2)) : 32'd0;
         if (irq === 1'b1) pulses++;
         read_reg(2'd2, v);
         n_cmp++;
         if (v !== exp_c) begin
            n_err++;
            $display("FAIL periodic_count j=%0d: got %0d expected %0d", j, v, exp_c);
         end
         n_cmp++;
         if (irq !== (o == 5)) begin
            n_err++;
            $display("FAIL periodic_irq j=%0d: got %b expected %b", j, irq, (o == 5));
         end
      end
      n_cmp++;
      if (pulses != 4) begin
         n_err++;
         $display("FAIL periodic_pulses: got %0d expected 4", pulses);
      end
   endtask

   task automatic test_masked();
      logic [31:0] v;
      do_reset();
      write_reg(2'd1, 32'd2);
      write_reg(2'd0, 32'h1);
      for (int j = 1; j <= 6; j++) begin
         cycle();
         n_cmp++;
         if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL masked_irq j=%0d: got %b expected 0", j, irq);
         end
      end
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_err++;
         $display("FAIL masked_count: got %0d expected 0", v);
      end
      read_reg(2'd0, v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_err++;
         $display("FAIL masked_ctrl: got %h expected 0", v);
      end
      write_reg(2'd0, 32'h8);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL masked_unmask k=%0d: got %b expected 0", k, irq);
         end
         cycle();
      end
   endtask

   task automatic test_disable();
      logic [31:0] v;
      do_reset();
      write_reg(2'd1, 32'd10);
      write_reg(2'd0, 32'h9);
      repeat (6) cycle();
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd6) begin
         n_err++;
         $display("FAIL disable_pre: got %0d expected 6", v);
      end
      write_reg(2'd0, 32'h8);
      for (int k = 0; k < 5; k++) begin
         read_reg(2'd2, v);
         n_cmp++;
         if (v !== 32'd5 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL disable_frozen k=%0d: got count %0d irq %b expected 5 irq 0", k, v, irq);
         end
         cycle();
      end
      write_reg(2'd1, 32'd7);
      cycle();
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd5) begin
         n_err++;
         $display("FAIL disable_preset_wr: got %0d expected 5", v);
      end
      write_reg(2'd0, 32'h9);
      cycle();
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd5) begin
         n_err++;
         $display("FAIL disable_reen_j1: got %0d expected 5", v);
      end
      cycle();
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd7) begin
         n_err++;
         $display("FAIL disable_reload: got %0d expected 7", v);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] v;
      do_reset();
      write_reg(2'd1, 32'd9);
      write_reg(2'd0, 32'hB);
      repeat (7) cycle();
      read_reg(2'd2, v);
      n_cmp++;
      if (v !== 32'd4) begin
         n_err++;
         $display("FAIL midreset_pre: got %0d expected 4", v);
      end
      do_reset();
      for (int k = 0; k < 5; k++) begin
         for (int r = 0; r < 3; r++) begin
            read_reg(2'(r), v);
            n_cmp++;
            if (v !== 32'd0) begin
               n_err++;
               $display("FAIL midreset_reg k=%0d off=%0d: got %h expected 0", k, r, v);
            end
         end
         n_cmp++;
         if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_irq k=%0d: got %b expected 0", k, irq);
         end
         cycle();
      end
      write_reg(2'd3, 32'hFFFF_FFFF);
      read_reg(2'd3, v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_err++;
         $display("FAIL rsvd_read: got %h expected 0", v);
      end
      read_reg(2'd0, v);
      n_cmp++;
      if (v !== 32'd0) begin
         n_err++;
         $display("FAIL rsvd_ctrl: got %h expected 0", v);
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      logic [31:0] exp_ctrl;
      int n;
      int mode;
      int e;
      int span;
      bit im;
      bit periodic;
      for (int it = 0; it < 10; it++) begin
         n        = $urandom_range(0, 12);
         mode     = $urandom_range(0, 3);
         im       = 1'($urandom_range(0, 1));
         periodic = (mode == 1);
         e        = ((n < 1) ? 1 : n) + 2;
         span     = periodic ? 3 * (e + 1) : e + 4;
         do_reset();
         write_reg(2'd1, 32'(n));
         write_reg(2'd0, {28'd0, im, 2'(mode), 1'b1});
         for (int j = 1; j <= span; j++) begin
            cycle();
            read_reg(2'd2, v);
            n_cmp++;
            if (v !== model_count(n, periodic, j)) begin
               n_err++;
               $display("FAIL rand_count it=%0d n=%0d mode=%0d j=%0d: got %0d expected %0d",
                        it, n, mode, j, v, model_count(n, periodic, j));
            end
            n_cmp++;
            if (irq !== model_irq(n, periodic, im, j)) begin
               n_err++;
               $display("FAIL rand_irq it=%0d n=%0d mode=%0d im=%0d j=%0d: got %b expected %b",
                        it, n, mode, im, j, irq, model_irq(n, periodic, im, j));
            end
            exp_ctrl = {28'd0, im, 2'(mode), (periodic || j <= e) ? 1'b1 : 1'b0};
            read_reg(2'd0, v);
            n_cmp++;
            if (v !== exp_ctrl) begin
               n_err++;
               $display("FAIL rand_ctrl it=%0d j=%0d: got %h expected %h", it, j, v, exp_ctrl);
            end
         end
         $display("random run %0d: preset=%0d mode=%0d im=%0d cycles=%0d", it, n, mode, im, span);
      end
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      cycle();
      cycle();
      reset = 1'b0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_masked();
      test_disable();
      test_reset_midcount();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
